full_logic_param: RTL and testbench

FULL_LOGIC_PARAM -- requirements
Module: full_logic_param

---
 rtl/full_logic_param_pkg.sv | 23 ++
 rtl/full_logic_param_fifo.sv | 85 ++++++++
 rtl/full_logic_param.sv | 206 ++++++++++++++++++++
 tb/tb_full_logic_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_logic_param_pkg.sv
// ---------------------------------------------------------------------------
// full_logic_param_pkg
// Shared definitions for the full_logic_param router: controller state
// encodings and the FIFO occupancy-count width rule.
// No ports (package).
// ---------------------------------------------------------------------------
package full_logic_param_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // A FIFO of 2^addr_width entries needs one extra count bit so that the
    // completely full case (count == DEPTH) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/full_logic_param_fifo.sv
// ---------------------------------------------------------------------------
// fifo_param
// Synchronous FIFO, 2^ADDR_WIDTH entries of DATA_WIDTH bits.  The head word
// is visible combinationally so the router can forward it in the same cycle.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset (pointers and count cleared)
//   push   in   write din (taken when not full, or when popping this cycle)
//   pop    in   remove head (ignored when empty)
//   din    in   write data
//   head   out  word at the read pointer
//   count  out  occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module fifo_param
    import full_logic_param_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [DATA_WIDTH-1:0]                head,
    output logic [count_width(ADDR_WIDTH)-1:0]   count,
    output logic                                 full,
    output logic                                 empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the slot being written: the write
    // pointer equals the read pointer, and the old head is consumed this
    // cycle before the new word lands at the edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage is not reset; clearing the pointers/count discards contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/full_logic_param.sv
// ---------------------------------------------------------------------------
// full_logic_param
// Main FIFO feeding NUM_DEST destination FIFOs.  The top DEST_BITS of each
// word select its destination.  A controller FSM latches almost-full margins
// during INIT, tracks IDLE/ACTIVE from FIFO occupancy and locks into ERROR on
// a main-FIFO overflow or a pop from an empty destination.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   init        in   commit thresholds, leave INIT
//   wr_enable   in   push data_in into the main FIFO
//   data_in     in   input word, MSBs select destination
//   umbral_MF   in   main-FIFO almost-full margin
//   umbral_D    in   destination-FIFO almost-full margin
//   pop         in   per-destination read request
//   data_out    out  registered read data, destination i at slice i
//   empty       out  per-destination empty flags
//   pause_out   out  main FIFO almost full
//   error_out   out  sticky error
//   active_out  out  state is ACTIVE
//   idle_out    out  state is IDLE
// ---------------------------------------------------------------------------
module full_logic_param
    import full_logic_param_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_DEST   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             init,
    input  logic                             wr_enable,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic [ADDR_WIDTH:0]              umbral_MF,
    input  logic [ADDR_WIDTH:0]              umbral_D,
    input  logic [NUM_DEST-1:0]              pop,
    output logic [NUM_DEST*DATA_WIDTH-1:0]   data_out,
    output logic [NUM_DEST-1:0]              empty,
    output logic                             pause_out,
    output logic                             error_out,
    output logic                             active_out,
    output logic                             idle_out
);

    localparam int DEST_BITS = (NUM_DEST == 4) ? 2 : 1;
    localparam int CW        = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);

    state_e state_q, state_d;

    logic [CW-1:0] umbral_mf_q, umbral_d_q;
    logic [CW-1:0] umbral_mf_clamped, umbral_d_clamped;

    // Main FIFO
    logic [DATA_WIDTH-1:0] m_head;
    logic [CW-1:0]         m_count;
    logic                  m_full, m_empty, m_push, m_pop;

    // Destination FIFOs
    logic [DATA_WIDTH-1:0] d_head  [NUM_DEST];
    logic [CW-1:0]         d_count [NUM_DEST];
    logic [NUM_DEST-1:0]   d_full, d_empty, d_push, d_pop;
    logic [DATA_WIDTH-1:0] dout_q  [NUM_DEST];

    logic [DEST_BITS-1:0]  dest_sel;
    logic [CW-1:0]         sel_count;
    logic                  sel_full;
    logic                  route;
    logic                  wr_ok, wr_err, pop_err, error_event, any_data;
    logic                  error_q;

    // Margins above DEPTH behave as DEPTH; clamp once when latched.
    assign umbral_mf_clamped = (umbral_MF > DEPTH_C) ? DEPTH_C : umbral_MF;
    assign umbral_d_clamped  = (umbral_D  > DEPTH_C) ? DEPTH_C : umbral_D;

    // ------------------------------------------------------------------
    // Routing: forward the main head when its destination is below the
    // almost-full limit; otherwise the head (and everything behind it)
    // waits.
    // ------------------------------------------------------------------
    assign dest_sel = m_head[DATA_WIDTH-1 -: DEST_BITS];

    always_comb begin
        sel_count = '0;
        sel_full  = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (dest_sel == DEST_BITS'(i)) begin
                sel_count = d_count[i];
                sel_full  = d_full[i];
            end
        end
    end

    assign route = !m_empty && !sel_full && (sel_count < (DEPTH_C - umbral_d_q));

    assign wr_ok   = (state_q == ST_INIT) || (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign m_pop   = route;
    // A write into a full main FIFO is still taken if the router frees a slot.
    assign m_push  = wr_enable && wr_ok && (!m_full || route);
    assign wr_err  = wr_enable && wr_ok && m_full && !route;
    assign pop_err = |(pop & d_empty);
    assign d_pop   = pop & ~d_empty;

    assign error_event = wr_err || pop_err;
    assign any_data    = !m_empty || !(&d_empty);

    fifo_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_main_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (m_push),
        .pop   (m_pop),
        .din   (data_in),
        .head  (m_head),
        .count (m_count),
        .full  (m_full),
        .empty (m_empty)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEST; gi++) begin : g_dest
            assign d_push[gi] = route && (dest_sel == DEST_BITS'(gi));

            fifo_param #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_dest_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (d_push[gi]),
                .pop   (d_pop[gi]),
                .din   (m_head),
                .head  (d_head[gi]),
                .count (d_count[gi]),
                .full  (d_full[gi]),
                .empty (d_empty[gi])
            );

            // Read data holds its last value unless a valid pop occurs.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q[gi] <= '0;
                end else if (d_pop[gi]) begin
                    dout_q[gi] <= d_head[gi];
                end
            end

            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                if (error_event)   state_d = ST_ERROR;
                else if (init)     state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (error_event)   state_d = ST_ERROR;
                else if (any_data) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (error_event)   state_d = ST_ERROR;
                else if (!any_data) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            umbral_mf_q <= '0;
            umbral_d_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Thresholds track the inputs throughout INIT, so the values
            // present on the edge that leaves INIT are the ones retained.
            if (state_q == ST_INIT) begin
                umbral_mf_q <= umbral_mf_clamped;
                umbral_d_q  <= umbral_d_clamped;
            end
            if (error_event && (state_q != ST_RESET)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign empty      = d_empty;
    assign pause_out  = (m_count >= (DEPTH_C - umbral_mf_q));
    assign error_out  = error_q;
    assign active_out = (state_q == ST_ACTIVE);
    assign idle_out   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_full_logic_param.sv
// ---------------------------------------------------------------------------
// tb_full_logic_param
// Self-checking bench for full_logic_param at default parameters
// (DATA_WIDTH=6, ADDR_WIDTH=2 -> DEPTH=4, NUM_DEST=2).  Words expected at a
// destination are queued when written and compared when popped.
// ---------------------------------------------------------------------------
module tb_full_logic_param;

    localparam int DW = 6;
    localparam int AW = 2;
    localparam int ND = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             init = 1'b0;
    logic             wr_enable = 1'b0;
    logic [DW-1:0]    data_in = '0;
    logic [AW:0]      umbral_MF = '0;
    logic [AW:0]      umbral_D = '0;
    logic [ND-1:0]    pop = '0;
    logic [ND*DW-1:0] data_out;
    logic [ND-1:0]    empty;
    logic             pause_out, error_out, active_out, idle_out;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    full_logic_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_DEST   (ND)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .wr_enable  (wr_enable),
        .data_in    (data_in),
        .umbral_MF  (umbral_MF),
        .umbral_D   (umbral_D),
        .pop        (pop),
        .data_out   (data_out),
        .empty      (empty),
        .pause_out  (pause_out),
        .error_out  (error_out),
        .active_out (active_out),
        .idle_out   (idle_out)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bring_up(input logic [AW:0] mf, input logic [AW:0] ud);
        reset = 1'b0;
        wr_enable = 1'b0;
        pop = '0;
        init = 1'b0;
        tick();
        reset = 1'b1;
        tick();                     // RESET -> INIT
        umbral_MF = mf;
        umbral_D  = ud;
        init = 1'b1;
        tick();                     // INIT -> IDLE, thresholds latched
        init = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Write one word; when it is expected to be delivered, queue it.
    task automatic write_word(input logic [DW-1:0] w, input logic expect_deliver);
        wr_enable = 1'b1;
        data_in = w;
        tick();
        wr_enable = 1'b0;
        if (expect_deliver) begin
            if (w[DW-1]) exp_q1.push_back(w);
            else         exp_q0.push_back(w);
        end
    endtask

    // Pop the selected destinations for one cycle and compare data_out.
    task automatic pop_cycle(input logic [ND-1:0] p, input string tag);
        logic [DW-1:0] exp_w;
        logic [DW-1:0] got_w;
        pop = p;
        tick();
        pop = '0;
        for (int i = 0; i < ND; i++) begin
            if (p[i]) begin
                if (i == 0) begin
                    exp_w = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
                end else begin
                    exp_w = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
                end
                got_w = data_out[i*DW +: DW];
                checks++;
                if (got_w !== exp_w) begin
                    failures++;
                    $display("FAIL %s data_out[%0d] got=%b exp=%b", tag, i, got_w, exp_w);
                end else begin
                    $display("pop %s dest%0d data=%b", tag, i, got_w);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++;
        if (empty !== 2'b11) begin failures++; $display("FAIL reset_empty got=%b exp=11", empty); end
        checks++;
        if ({pause_out, error_out, active_out, idle_out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {pause_out, error_out, active_out, idle_out});
        end
        reset = 1'b1;
        tick();                     // now in INIT
        checks++;
        if ({active_out, idle_out} !== 2'b00) begin
            failures++;
            $display("FAIL init_state_flags got=%b exp=00", {active_out, idle_out});
        end
        umbral_MF = 3'd1;
        umbral_D  = 3'd2;
        init = 1'b1;
        tick();
        init = 1'b0;
        checks++;
        if (idle_out !== 1'b1) begin failures++; $display("FAIL init_to_idle idle_out got=%b exp=1", idle_out); end
        checks++;
        if (error_out !== 1'b0) begin failures++; $display("FAIL init_error got=%b exp=0", error_out); end
        checks++;
        if (pause_out !== 1'b0) begin failures++; $display("FAIL init_pause got=%b exp=0", pause_out); end
        $display("reset/init done idle=%b error=%b", idle_out, error_out);
    endtask

    task automatic test_route();
        write_word(6'b001000, 1'b1);
        write_word(6'b100101, 1'b1);
        tick();
        tick();
        checks++;
        if (active_out !== 1'b1) begin failures++; $display("FAIL route_active got=%b exp=1", active_out); end
        checks++;
        if (empty !== 2'b00) begin failures++; $display("FAIL route_empty got=%b exp=00", empty); end
        pop_cycle(2'b11, "route");
        checks++;
        if (empty !== 2'b11) begin failures++; $display("FAIL route_drained_empty got=%b exp=11", empty); end
        tick();
        checks++;
        if (idle_out !== 1'b1) begin failures++; $display("FAIL route_back_idle got=%b exp=1", idle_out); end
        checks++;
        if (error_out !== 1'b0) begin failures++; $display("FAIL route_error got=%b exp=0", error_out); end
    endtask

    // umbral_D=2 caps D0 at 2 words; main fills behind the blocked head.
    // Main count after each write: 1,1,1,2,3,4, then the 7th overflows.
    task automatic test_hol_pause();
        logic [6:0] exp_pause;
        logic [6:0] exp_err;
        exp_pause = 7'b1110000;     // bit k-1 for write k
        exp_err   = 7'b1000000;
        for (int k = 1; k <= 7; k++) begin
            write_word({1'b0, 5'(k)}, 1'b0);
            checks++;
            if (pause_out !== exp_pause[k-1]) begin
                failures++;
                $display("FAIL hol_pause write%0d got=%b exp=%b", k, pause_out, exp_pause[k-1]);
            end
            checks++;
            if (error_out !== exp_err[k-1]) begin
                failures++;
                $display("FAIL hol_error write%0d got=%b exp=%b", k, error_out, exp_err[k-1]);
            end
            $display("write %0d pause=%b error=%b", k, pause_out, error_out);
        end
        checks++;
        if ({active_out, idle_out} !== 2'b00) begin
            failures++;
            $display("FAIL hol_error_state got=%b exp=00", {active_out, idle_out});
        end
    endtask

    task automatic test_pop_empty();
        bring_up(3'd1, 3'd2);
        pop = 2'b01;
        tick();
        pop = '0;
        checks++;
        if (error_out !== 1'b1) begin failures++; $display("FAIL pop_empty_error got=%b exp=1", error_out); end
        checks++;
        if ({active_out, idle_out} !== 2'b00) begin
            failures++;
            $display("FAIL pop_empty_state got=%b exp=00", {active_out, idle_out});
        end
        checks++;
        if (data_out[DW-1:0] !== '0) begin
            failures++;
            $display("FAIL pop_empty_data got=%b exp=0", data_out[DW-1:0]);
        end
        write_word(6'b100001, 1'b0);
        tick();
        tick();
        checks++;
        if (empty !== 2'b11) begin failures++; $display("FAIL error_write_ignored empty got=%b exp=11", empty); end
        checks++;
        if ({pause_out, active_out} !== 2'b00) begin
            failures++;
            $display("FAIL error_write_flags got=%b exp=00", {pause_out, active_out});
        end
        $display("pop-on-empty error=%b empty=%b", error_out, empty);
    endtask

    // umbral_D=0: D1 fills to 4, fifth word waits in main; back-to-back pops
    // drain D1 while the fifth word is forwarded on the cycle after the first pop.
    task automatic test_full_pop();
        bring_up(3'd0, 3'd0);
        for (int k = 1; k <= 5; k++) begin
            write_word({1'b1, 5'(k)}, 1'b1);
        end
        tick();
        tick();
        checks++;
        if (empty !== 2'b01) begin failures++; $display("FAIL full_fill_empty got=%b exp=01", empty); end
        checks++;
        if (pause_out !== 1'b0) begin failures++; $display("FAIL full_fill_pause got=%b exp=0", pause_out); end
        for (int k = 0; k < 5; k++) begin
            pop_cycle(2'b10, "full");
            checks++;
            if (error_out !== 1'b0) begin failures++; $display("FAIL full_pop_error pop%0d got=%b exp=0", k, error_out); end
        end
        checks++;
        if (empty !== 2'b11) begin failures++; $display("FAIL full_drained got=%b exp=11", empty); end
    endtask

    // Streamed writes alternating destinations, then simultaneous drains.
    task automatic test_back_to_back();
        bring_up(3'd0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            write_word({k[0], 5'(k + 3)}, 1'b1);
        end
        tick();
        checks++;
        if (error_out !== 1'b0) begin failures++; $display("FAIL b2b_write_error got=%b exp=0", error_out); end
        checks++;
        if (empty !== 2'b00) begin failures++; $display("FAIL b2b_empty got=%b exp=00", empty); end
        for (int k = 0; k < 4; k++) begin
            pop_cycle(2'b11, "b2b");
        end
        checks++;
        if (empty !== 2'b11) begin failures++; $display("FAIL b2b_drained got=%b exp=11", empty); end
        tick();
        checks++;
        if (idle_out !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b exp=1", idle_out); end
    endtask

    initial begin
        test_reset();
        test_route();
        test_hol_pause();
        test_pop_empty();
        test_full_pop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
